// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register completer.
// Optional build macro: APB_SLVERR_EN (adds PSLVERR to the top level).
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 32;

  localparam logic [APB_DATA_W-1:0] APB_ID_DEFAULT = 32'hA9B0_0001;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  // Word-aligned and inside the implemented register window.
  function automatic logic apb_addr_ok(
    input logic [APB_ADDR_W-1:0] a,
    input int                    nregs
  );
    return (a[1:0] == 2'b00) && (int'(a[7:2]) < nregs);
  endfunction

endpackage

// File: rtl/apb_slave_regbank.sv
// Register storage, index decode, range check and read mux.
// Optional build macro: APB_SLVERR_EN (adds the access error flag).
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS = 16,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = APB_ID_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  we,
  input  logic [APB_ADDR_W-1:0] waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [APB_ADDR_W-1:0] raddr,
  output logic [APB_DATA_W-1:0] rdata
`ifdef APB_SLVERR_EN
  ,
  input  logic                  rwrite,
  output logic                  rerr
`endif
);

  logic [5:0] widx;
  logic [5:0] ridx;
  logic       wok;
  logic       rok;

  logic [APB_DATA_W-1:0] regs [1:NUM_REGS-1];

  assign widx = waddr[7:2];
  assign ridx = raddr[7:2];
  assign wok  = apb_addr_ok(waddr, NUM_REGS);
  assign rok  = apb_addr_ok(raddr, NUM_REGS);

  // Index 0 never matches the loop, so ID writes fall away here.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && wok) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (widx == 6'(i)) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rok) begin
      if (ridx == 6'd0) begin
        rdata = ID_VALUE;
      end else begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (ridx == 6'(i)) begin
            rdata = regs[i];
          end
        end
      end
    end
  end

`ifdef APB_SLVERR_EN
  assign rerr = !rok || (rwrite && (ridx == 6'd0));
`endif

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer: setup/access FSM, wait-state counter, registered PREADY.
// Optional build macro: APB_SLVERR_EN (adds PSLVERR output).
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = APB_ID_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic                  PREADY,
  output logic [APB_DATA_W-1:0] PRDATA
`ifdef APB_SLVERR_EN
  ,
  output logic                  PSLVERR
`endif
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  apb_state_e state_q, state_d;
  apb_req_t   req_q, req_d;

  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_d;
  logic [APB_DATA_W-1:0] prdata_d;
  logic                  setup;
  logic                  done;
  logic                  rise;
  logic                  we;
  logic [APB_ADDR_W-1:0] raddr;
  logic                  rwr;
  logic [APB_DATA_W-1:0] rdata;
`ifdef APB_SLVERR_EN
  logic                  rerr;
  logic                  err_d;
`endif

  assign setup = PSEL & ~PENABLE;
  assign done  = PSEL & PENABLE & PREADY;

  apb_slave_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .we      (we),
    .waddr   (req_q.addr),
    .wdata   (req_q.wdata),
    .raddr   (raddr),
    .rdata   (rdata)
`ifdef APB_SLVERR_EN
    ,
    .rwrite  (rwr),
    .rerr    (rerr)
`endif
  );

  // Read port follows the live bus in IDLE so a zero-wait read
  // sees a write that closed on the previous edge.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    pready_d = PREADY;
    prdata_d = PRDATA;
    rise     = 1'b0;
    we       = 1'b0;
    raddr    = req_q.addr;
    rwr      = req_q.write;
`ifdef APB_SLVERR_EN
    err_d    = PSLVERR;
`endif
    unique case (state_q)
      IDLE: begin
        pready_d = 1'b0;
        prdata_d = '0;
        raddr    = PADDR;
        rwr      = PWRITE;
`ifdef APB_SLVERR_EN
        err_d    = 1'b0;
`endif
        if (setup) begin
          req_d   = '{addr: PADDR, write: PWRITE, wdata: PWDATA};
          cnt_d   = WAIT_LD;
          state_d = ACCESS;
          rise    = (WAIT_LD == 4'd0);
        end
      end
      ACCESS: begin
        if (!PSEL || done) begin
          we       = done & req_q.write;
          state_d  = IDLE;
          cnt_d    = 4'd0;
          pready_d = 1'b0;
          prdata_d = '0;
`ifdef APB_SLVERR_EN
          err_d    = 1'b0;
`endif
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
          rise  = (cnt_q == 4'd1);
        end
      end
    endcase
    if (rise) begin
      pready_d = 1'b1;
      prdata_d = rwr ? '0 : rdata;
`ifdef APB_SLVERR_EN
      err_d    = rerr;
`endif
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= 4'd0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
`ifdef APB_SLVERR_EN
      PSLVERR <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      PREADY  <= pready_d;
      PRDATA  <= prdata_d;
`ifdef APB_SLVERR_EN
      PSLVERR <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Bench: four completers with different wait counts against an array model.
// Optional build macro: APB_SLVERR_EN (checks PSLVERR as well).
module tb_apb_reg_slave;

  localparam int NR = 16;
  localparam int ND = 4;
  localparam int WS [ND] = '{1, 0, 2, 3};
  localparam logic [31:0] IDV = 32'hA9B0_0001;

  logic clk = 1'b0;
  logic rst_n;

  logic [ND-1:0]       psel;
  logic [ND-1:0]       penable;
  logic [ND-1:0]       pwrite;
  logic [ND-1:0]       pready;
  logic [ND-1:0][7:0]  paddr;
  logic [ND-1:0][31:0] pwdata;
  logic [ND-1:0][31:0] prdata;
`ifdef APB_SLVERR_EN
  logic [ND-1:0]       pslverr;
`endif

  logic [31:0] mem [ND][NR];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb_reg_slave #(
      .NUM_REGS    (NR),
      .WAIT_CYCLES (WS[g]),
      .ID_VALUE    (IDV)
    ) dut (
      .PCLK    (clk),
      .PRESETn (rst_n),
      .PSEL    (psel[g]),
      .PENABLE (penable[g]),
      .PADDR   (paddr[g]),
      .PWRITE  (pwrite[g]),
      .PWDATA  (pwdata[g]),
      .PREADY  (pready[g]),
      .PRDATA  (prdata[g])
`ifdef APB_SLVERR_EN
      ,
      .PSLVERR (pslverr[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit a_bad(input logic [7:0] a);
    return (a[1:0] != 2'b00) || (int'(a[7:2]) >= NR);
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [7:0] a);
    if (a_bad(a)) return 32'h0;
    if (a[7:2] == 6'd0) return IDV;
    return mem[d][int'(a[7:2])];
  endfunction

  task automatic m_clear();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < NR; i++) mem[d][i] = 32'h0;
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                      input logic [31:0] wd);
    int cyc;
    bit got;
    logic [31:0] rd;
    logic er;
    rd = 32'h0;
    er = 1'b0;
    psel[d] = 1'b1;
    penable[d] = 1'b0;
    paddr[d] = a;
    pwrite[d] = wr;
    pwdata[d] = wd;
    @(negedge clk);
    chk("t0_ready", 32'(pready[d]), 32'h0);
    chk("t0_rdata", prdata[d], 32'h0);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    paddr[d] = 8'($urandom);
    pwdata[d] = $urandom;
    cyc = 1;
    got = 0;
    while (!got && cyc <= 40) begin
      @(negedge clk);
      if (pready[d]) begin
        got = 1;
        rd = prdata[d];
`ifdef APB_SLVERR_EN
        er = pslverr[d];
`endif
      end else begin
        cyc++;
      end
      @(posedge clk); #1;
    end
    chk("latency", 32'(cyc), 32'(WS[d] + 1));
    if (!wr) chk("rdata", rd, m_read(d, a));
`ifdef APB_SLVERR_EN
    chk("slverr", 32'(er),
        32'(a_bad(a) || (wr && a[7:2] == 6'd0)));
`endif
    if (wr && !a_bad(a) && a[7:2] != 6'd0) mem[d][int'(a[7:2])] = wd;
    psel[d] = 1'b0;
    penable[d] = 1'b0;
  endtask

  task automatic abort_xfer(input int d, input logic [7:0] a,
                            input logic [31:0] wd);
    psel[d] = 1'b1;
    penable[d] = 1'b0;
    paddr[d] = a;
    pwrite[d] = 1'b1;
    pwdata[d] = wd;
    @(posedge clk); #1;
    psel[d] = 1'b0;
    @(negedge clk);
    if (WS[d] > 0) chk("abort_t1_ready", 32'(pready[d]), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_ready", 32'(pready[d]), 32'h0);
    chk("abort_rdata", prdata[d], 32'h0);
    @(posedge clk); #1;
  endtask

  // Drives to the completion cycle, then pulls reset before the edge.
  task automatic reset_in_flight(input int d, input bit wr,
                                 input logic [7:0] a, input logic [31:0] wd);
    psel[d] = 1'b1;
    penable[d] = 1'b0;
    paddr[d] = a;
    pwrite[d] = wr;
    pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    repeat (WS[d]) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_pre_ready", 32'(pready[d]), 32'h1);
    if (!wr) chk("rst_pre_rdata", prdata[d], m_read(d, a));
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(pready[d]), 32'h0);
    chk("rst_rdata", prdata[d], 32'h0);
    psel[d] = 1'b0;
    penable[d] = 1'b0;
    m_clear();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    psel = '0;
    penable = '0;
    pwrite = '0;
    paddr = '0;
    pwdata = '0;
    m_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk("reset_ready", 32'(pready[d]), 32'h0);
      chk("reset_rdata", prdata[d], 32'h0);
    end
    @(posedge clk); #1;

    reset_in_flight(3, 1'b0, 8'h00, 32'h0);
    reset_in_flight(3, 1'b1, 8'h04, 32'h55AA_1234);
    xfer(3, 1'b0, 8'h04, 32'h0);

    xfer(0, 1'b1, 8'h08, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 8'h08, 32'h0);

    xfer(1, 1'b1, 8'h0C, 32'h1234_5678);
    xfer(1, 1'b0, 8'h0C, 32'h0);

    xfer(0, 1'b0, 8'h00, 32'h0);
    xfer(0, 1'b1, 8'h00, 32'h0);
    xfer(0, 1'b0, 8'h00, 32'h0);

    xfer(0, 1'b1, 8'h04, 32'h0BAD_F00D);
    xfer(0, 1'b0, 8'h40, 32'h0);
    xfer(0, 1'b1, 8'h06, 32'hFFFF_0000);
    xfer(0, 1'b0, 8'h04, 32'h0);
    xfer(0, 1'b0, 8'h06, 32'h0);

    abort_xfer(2, 8'h10, 32'hFFFF_FFFF);
    xfer(2, 1'b0, 8'h10, 32'h0);
    abort_xfer(1, 8'h10, 32'hFFFF_FFFF);
    xfer(1, 1'b0, 8'h10, 32'h0);

    psel[0] = 1'b1;
    penable[0] = 1'b1;
    paddr[0] = 8'h08;
    pwrite[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_setup_ready", 32'(pready[0]), 32'h0);
      @(posedge clk); #1;
    end
    psel[0] = 1'b0;
    penable[0] = 1'b0;

    for (int n = 0; n < 400; n++) begin
      int d;
      logic [7:0] a;
      d = $urandom_range(0, ND - 1);
      if ($urandom_range(0, 3) == 0) a = 8'($urandom);
      else a = {6'($urandom_range(0, NR - 1)), 2'b00};
      if ($urandom_range(0, 9) == 0) abort_xfer(d, a, $urandom);
      else xfer(d, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    for (int d = 0; d < ND; d++)
      for (int i = 0; i < NR; i++) xfer(d, 1'b0, 8'(i * 4), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
